// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue -- fetch-to-decode instruction queue
//
// A small circular FIFO between the fetch and decode stages. Fetch pushes
// {pc, instr} pairs and decode pops them in order. A flush from decode
// (taken branch or jump) empties the queue in one cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   pcF        PC of the fetched instruction
//   instrF     instruction word fetched at pcF
//   validF     fetch offers {pcF, instrF} this cycle
//   readyF     queue has room; also acts as the PC register enable
//   readyD     decode consumes the head entry this cycle
//   validD     head entry is valid
//   instrD     head instruction (NOP when validD is low)
//   pcD        head PC (0 when validD is low)
//   pc_plus4D  pcD + 4 (0 when validD is low)
//   flushD     discard every queued entry
//   count      number of valid entries
//   err        sticky flag: decode pulled from an empty queue
// -----------------------------------------------------------------------------
module if_id_queue #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                pcF,
   input  logic [31:0]                instrF,
   input  logic                       validF,
   output logic                       readyF,
   input  logic                       readyD,
   output logic                       validD,
   output logic [31:0]                instrD,
   output logic [31:0]                pcD,
   output logic [31:0]                pc_plus4D,
   input  logic                       flushD,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Entry storage is never reset; only pointers, count and err carry state
   // that matters after reset or flush.
   logic [31:0]      pc_mem_q    [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             push, pop;

   // Handshakes depend only on registered occupancy, so there is no
   // combinational path from validF/readyD back to readyF/validD.
   assign readyF = (cnt_q != CNT_W'(DEPTH));
   assign validD = (cnt_q != '0);

   assign push = validF & readyF & ~flushD;
   assign pop  = validD & readyD & ~flushD;

   // Pointers are exactly PTR_W bits wide and DEPTH is a power of two,
   // so the natural binary wrap gives modulo-DEPTH advance.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q | (readyD & ~validD & ~flushD);
      if (flushD) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= pcF;
         instr_mem_q[wr_ptr_q] <= instrF;
      end
   end

   // Head outputs are gated by validD so an empty queue presents a NOP.
   assign instrD    = validD ? instr_mem_q[rd_ptr_q]         : 32'h0;
   assign pcD       = validD ? pc_mem_q[rd_ptr_q]            : 32'h0;
   assign pc_plus4D = validD ? pc_mem_q[rd_ptr_q] + 32'd4    : 32'h0;

   assign count = cnt_q;
   assign err   = err_q;

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of fetch-queue entries; SHALL be a power of two, 2..8.
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 pcF  input  32  PC of the fetched instruction, taken from the PC register output.
REQ-005 instrF  input  32  instruction word read from instruction memory at pcF.
REQ-006 validF  input  1  fetch offers {pcF, instrF} this cycle.
REQ-007 readyF  output  1  queue can accept a push this cycle; drives the PC register enable (advance when high).
REQ-008 readyD  input  1  decode consumes the head entry this cycle.
REQ-009 validD  output  1  head entry is valid.
REQ-010 instrD  output  32  head instruction; 32'h0000_0000 (NOP) when validD is low.
REQ-011 pcD  output  32  head PC; 32'h0 when validD is low.
REQ-012 pc_plus4D  output  32  pcD + 4, modulo 2^32; 32'h0 when validD is low.
REQ-013 flushD  input  1  discard all queued entries (branch taken/jump).
REQ-014 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 Storage: DEPTH entries of {pc[31:0], instr[31:0]}, circular buffer with write pointer, read pointer and occupancy count.
REQ-017 push = validF & readyF & !flushD; pop = validD & readyD & !flushD.
REQ-018 readyF SHALL be (count < DEPTH), from registered state only; there is no combinational path validF/readyD -> readyF.
REQ-019 validD SHALL be (count != 0); head outputs SHALL come from the entry at the read pointer, with no combinational path from instrF/pcF.
REQ-020 Push: entry written at the write pointer, pointer +1 modulo DEPTH, count +1, visible at the head no earlier than the next cycle (minimum latency 1 cycle).
REQ-021 Pop: read pointer +1 modulo DEPTH, count -1.
REQ-022 Simultaneous push and pop: both pointers advance, count unchanged; permitted at any count except full (no push when full) and empty (no pop when empty).
REQ-023 Full (count == DEPTH): readyF low; validF ignored; stored data unchanged.
REQ-024 Empty (count == 0): validD low; readyD ignored; outputs at NOP values.
REQ-025 Pointer wrap: DEPTH-1 -> 0 on both pointers, without losing order; FIFO order SHALL always be preserved.
REQ-026 Flush: priority over push and pop; next cycle count = 0, both pointers = 0; a same-cycle validF entry is discarded.
REQ-027 err SHALL set when readyD is high while validD is low and flushD is low (decode pulls from an empty queue); it remains set until reset.
REQ-028 Entry storage need not be cleared by flush or reset; only pointers, count and err are reset.

Reset
REQ-029 While rst is low: count = 0, pointers = 0, err = 0, validD = 0, readyF = 1, instrD = pcD = pc_plus4D = 0, asserted asynchronously, without waiting for clk.
REQ-030 Reset asserted mid-operation SHALL discard all entries; first push is accepted on the first rising edge after rst goes high.

Verification
REQ-031 Reset, then push pc=0x0/instr=0x20080005 with readyD=0 -> next cycle validD=1, instrD=0x20080005, pc_plus4D=0x4, count=1.
REQ-032 DEPTH=2, readyD=0, push 3 consecutive cycles (pc 0x0,0x4,0x8) -> readyF low after 2 pushes, count=2, third entry not stored; then readyD=1 -> pops 0x0 then 0x4.
REQ-033 Continuous validF=1/readyD=1 for 10 cycles with pc 0x0..0x24 -> pcD sequence in order across pointer wrap, count stays 1.
REQ-034 Queue holding 2 entries, flushD=1 with validF=1 -> next cycle count=0, validD=0, instrD=0; the flushed-cycle entry never appears.
REQ-035 Empty queue, readyD=1 for one cycle -> err=1, stays 1 through later traffic until rst low.
REQ-036 rst pulsed low between clock edges with count=2 -> outputs zero immediately, count=0, readyF=1.
